// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared width and access-size codes for the memory access stage
package mem_access_pkg;

   // Data/address width; the lane logic assumes 32-bit words
   localparam int XLEN_DEF = 32;

   // opfunc3 access-size codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // True when the size code is legal and the low address bits suit that size
   function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      case (f3)
         F3_B, F3_BU: return 1'b1;
         F3_H, F3_HU: return ~addr_lo[0];
         F3_W:        return (addr_lo == 2'b00);
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-enable, store-lane replication and load lane select/extend
module mem_align
   import mem_access_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
)
(
   input  logic [2:0]      f3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [3:0]      be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed byte and halfword out of the returned word
   always_comb begin
      w_byte = rdata_i[7:0];
      case (addr_lo_i)
         2'd0: w_byte = rdata_i[7:0];
         2'd1: w_byte = rdata_i[15:8];
         2'd2: w_byte = rdata_i[23:16];
         2'd3: w_byte = rdata_i[31:24];
         default: w_byte = rdata_i[7:0];
      endcase
      w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Size-dependent enables, store replication and load extension
   always_comb begin
      be_o    = 4'b0000;
      wdata_o = wdata_i;
      rdata_o = '0;
      case (f3_i)
         F3_B: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{w_byte[7]}}, w_byte};
         end
         F3_BU: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {24'd0, w_byte};
         end
         F3_H: begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{w_half[15]}}, w_half};
         end
         F3_HU: begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {16'd0, w_half};
         end
         F3_W: begin
            be_o    = 4'b1111;
            wdata_o = wdata_i;
            rdata_o = rdata_i;
         end
         default: begin
            be_o    = 4'b0000;
            wdata_o = wdata_i;
            rdata_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory stage: data-bus request/grant/response sequencing and writeback
module mem_access
   import mem_access_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
)
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [4:0]      rd_addr_i,
   input  logic [XLEN-1:0] rd_data_i,
   input  logic            rd_we_i,
   input  logic [XLEN-1:0] mem_addr_i,
   input  logic            mem_re_i,
   input  logic            mem_we_i,
   input  logic [2:0]      opfunc3_i,
   output logic            dreq_o,
   output logic            dwe_o,
   output logic [XLEN-1:0] daddr_o,
   output logic [XLEN-1:0] dwdata_o,
   output logic [3:0]      dbe_o,
   input  logic            dgnt_i,
   input  logic            drvalid_i,
   input  logic [XLEN-1:0] drdata_i,
   output logic [4:0]      rd_addr_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic            rd_we_o,
   output logic            stall_o,
   output logic            misalign_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   // Transaction captured on acceptance; the bus is driven from these only
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_data;
   logic [4:0]      r_rd_addr;
   logic            r_rd_we;
   logic [2:0]      r_f3;
   logic            r_store;

   logic [4:0]      r_rd_addr_o;
   logic [XLEN-1:0] r_rd_data_o;
   logic            r_rd_we_o;
   logic            r_misalign;

   logic            w_mem_op;
   logic            w_aligned;
   logic            w_start;
   logic            w_misalign;
   logic            w_stall;
   logic            w_in_req;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata;
   logic [XLEN-1:0] w_load_data;

   assign w_mem_op   = mem_re_i | mem_we_i;
   assign w_aligned  = f3_aligned(opfunc3_i, mem_addr_i[1:0]);
   assign w_start    = w_mem_op & w_aligned;
   assign w_misalign = w_mem_op & ~w_aligned;
   assign w_in_req   = (r_state == S_REQ);

   mem_align #(.XLEN(XLEN)) u_align (
      .f3_i      (r_f3),
      .addr_lo_i (r_addr[1:0]),
      .wdata_i   (r_data),
      .rdata_i   (drdata_i),
      .be_o      (w_be),
      .wdata_o   (w_wdata),
      .rdata_o   (w_load_data)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next state and hold request; a load's grant cycle still stalls since its data is not back
   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_next  = S_REQ;
               w_stall = 1'b1;
            end
         end
         S_REQ: begin
            if (dgnt_i) w_next = r_store ? S_IDLE : S_WAIT;
            w_stall = ~(dgnt_i & r_store);
         end
         S_WAIT: begin
            if (drvalid_i) w_next = S_IDLE;
            w_stall = ~drvalid_i;
         end
         default: begin
            w_next  = S_IDLE;
            w_stall = 1'b0;
         end
      endcase
   end

   // Capture the accepted transaction so the bus stays stable until grant
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_addr    <= '0;
         r_data    <= '0;
         r_rd_addr <= '0;
         r_rd_we   <= 1'b0;
         r_f3      <= F3_B;
         r_store   <= 1'b0;
      end else if (r_state == S_IDLE && w_start) begin
         r_addr    <= mem_addr_i;
         r_data    <= rd_data_i;
         r_rd_addr <= rd_addr_i;
         r_rd_we   <= rd_we_i;
         r_f3      <= opfunc3_i;
         r_store   <= mem_we_i;
      end
   end

   // Writeback register: pass-through when idle, load result on response, bubble otherwise
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rd_addr_o <= '0;
         r_rd_data_o <= '0;
         r_rd_we_o   <= 1'b0;
         r_misalign  <= 1'b0;
      end else begin
         r_rd_we_o  <= 1'b0;
         r_misalign <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_rd_addr_o <= rd_addr_i;
               r_rd_data_o <= rd_data_i;
               r_rd_we_o   <= rd_we_i & ~w_mem_op;
               r_misalign  <= w_misalign;
            end
            S_WAIT: begin
               if (drvalid_i) begin
                  r_rd_addr_o <= r_rd_addr;
                  r_rd_data_o <= w_load_data;
                  r_rd_we_o   <= r_rd_we & (r_rd_addr != 5'd0);
               end
            end
            default: begin
               r_rd_we_o <= 1'b0;
            end
         endcase
      end
   end

   assign dreq_o     = w_in_req;
   assign dwe_o      = w_in_req & r_store;
   assign dbe_o      = w_in_req ? w_be : 4'b0000;
   assign daddr_o    = {r_addr[XLEN-1:2], 2'b00};
   assign dwdata_o   = w_wdata;
   assign rd_addr_o  = r_rd_addr_o;
   assign rd_data_o  = r_rd_data_o;
   assign rd_we_o    = r_rd_we_o;
   assign misalign_o = r_misalign;
   assign stall_o    = rst_ni & w_stall;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  in  1  reset, synchronous and active-low.
REQ-004 From execute: rd_addr_i in 5; rd_data_i in XLEN (ALU result or store data); rd_we_i in 1; mem_addr_i in XLEN; mem_re_i in 1; mem_we_i in 1; opfunc3_i in 3.
REQ-005 Data bus: dreq_o out 1; dwe_o out 1; daddr_o out XLEN (word-aligned, [1:0]=0); dwdata_o out XLEN; dbe_o out 4; dgnt_i in 1; drvalid_i in 1; drdata_i in XLEN.
REQ-006 To writeback/forwarding: rd_addr_o out 5; rd_data_o out XLEN; rd_we_o out 1.
REQ-007 To pipectrl: stall_o out 1 (hold upstream); misalign_o out 1 (one-cycle exception pulse).

Function
REQ-008 Non-memory op (mem_re_i=mem_we_i=0) SHALL pass rd_addr/rd_data/rd_we to outputs with 1-cycle latency, stall_o=0.
REQ-009 mem_we_i=1 SHALL be a store regardless of mem_re_i (store priority).
REQ-010 opfunc3: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; other codes with a memory op SHALL be treated as misaligned.
REQ-011 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) SHALL issue no bus request, pulse misalign_o for 1 cycle, register rd_we_o=0, stall_o=0.
REQ-012 FSM states IDLE, REQ, WAIT; IDLE->REQ on aligned memory op; REQ->IDLE on dgnt_i for store; REQ->WAIT on dgnt_i for load; WAIT->IDLE on drvalid_i.
REQ-013 On IDLE->REQ the block SHALL latch address, data, rd_addr, opfunc3 and direction; bus outputs come from latched values only.
REQ-014 dreq_o SHALL be 1 exactly in REQ and held with stable dwe/daddr/dwdata/dbe until dgnt_i.
REQ-015 dbe_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; loads SHALL drive the same enables.
REQ-016 dwdata_o: byte replicated to all 4 lanes, half replicated to both halves, word unchanged.
REQ-017 Load data SHALL be the selected lane of drdata_i, sign-extended (000,001) or zero-extended (100,101).
REQ-018 stall_o SHALL be 1 combinationally when IDLE with aligned memory op, in REQ without dgnt_i, in WAIT without drvalid_i; 0 otherwise (completion cycle).
REQ-019 Latency: store completes in cycle 1 after acceptance at earliest; load result registered at end of cycle 2 at earliest; each extra wait cycle adds 1.
REQ-020 rd_we_o SHALL be 0 for every cycle a memory op is outstanding (bubble) and for stores; 1 only on load completion with latched rd_we.
REQ-021 drvalid_i outside WAIT and dgnt_i outside REQ SHALL be ignored.
REQ-022 Load to rd_addr 0 SHALL complete on the bus but register rd_we_o=0.

Reset
REQ-023 With rst_ni=0 at a clock edge: state=IDLE; rd_addr_o=0, rd_data_o=0, rd_we_o=0, misalign_o=0, dreq_o=0, dwe_o=0, daddr_o=0, dwdata_o=0, dbe_o=0.
REQ-024 stall_o SHALL be 0 while rst_ni=0.
REQ-025 Reset in REQ or WAIT SHALL abandon the transaction; a late drvalid_i after reset SHALL be ignored.

Structure
REQ-026 XLEN and opfunc3 width codes SHALL live in the shared defines header; FSM state encoding SHALL be local.
REQ-027 Lane select/extend and byte-enable/replicate logic SHALL be one combinational sub-module, mem_align.

Verification
REQ-028 SW addr 0x1004, data 0xDEADBEEF, dgnt_i first REQ cycle -> dbe_o=1111, daddr_o=0x1004, stall_o 1,0, rd_we_o stays 0.
REQ-029 LB addr 0x2003, drdata_i=0x80FF_FF_FF (lane3=0x80), dgnt then drvalid next cycle -> rd_data_o=0xFFFFFF80, rd_we_o=1 for one cycle.
REQ-030 LHU addr 0x2002, drdata_i=0x8001_1234, 3 wait cycles before dgnt -> dreq_o held 4 cycles stable, rd_data_o=0x00008001.
REQ-031 SH addr 0x3002 data 0x0000ABCD -> dwdata_o=0xABCDABCD, dbe_o=1100.
REQ-032 LW addr 0x4001 -> dreq_o never 1, misalign_o one pulse, rd_we_o=0, stall_o=0.
REQ-033 rst_ni=0 while in WAIT, drvalid_i next cycle -> all outputs 0, state IDLE, no writeback.
